// File: rtl/adc3v_12bit_pkg.sv
// Shared definitions for the 3V 12-bit SAR ADC controller.
//   sar_state_t       : controller FSM states
//   DEF_*             : default resolution and window lengths
//   TMR_W             : window timer width (covers 1..255 sample clocks)
//   idx_width()       : width of the bit-index counter for a given resolution
//   BIT_IDX_W         : bit-index counter width at the default resolution
package adc3v_12bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_t;

  localparam int DEF_WIDTH         = 12;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  localparam int TMR_W = 8;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int BIT_IDX_W = idx_width(DEF_WIDTH);

endpackage

// File: rtl/adc3v_sar_timer.sv
// Loadable down-counter with terminal-count flag. Times both the sample
// window and each per-bit settle window of the SAR controller.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_load      : load i_load_val this clock (priority over counting)
//   i_load_val  : window length minus one
//   o_tc        : high while the count is zero (last clock of the window)
module adc3v_sar_timer
  import adc3v_12bit_pkg::*;
#(
  parameter int CNT_W = TMR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/adc3v_12bit_sar_ctrl.sv
// Successive-approximation controller for the 3V 12-bit SAR ADC macro.
// Drives the macro's enable, sample-cap reset, hold and DAC code; resolves
// one bit per settle window from the comparator, MSB first, and presents the
// result with a one-cycle valid strobe.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   en           : enable; low aborts to IDLE on the next clock
//   start        : conversion request, honoured only in IDLE with en high
//   comp_in      : comparator, 1 = held value > DAC value
//   adc_ena      : registered copy of en
//   adc_reset    : sample-cap reset, high on the first SAMPLE clock
//   adc_hold     : high throughout CONVERT
//   adc_dac_val  : trial code to the DAC
//   data_out     : last completed result
//   data_valid   : one-cycle strobe in DONE
//   busy         : high in any state except IDLE
//   o_dbg_state  : current FSM state
//
// Request/result protocol: start is a level sampled only while IDLE and en is
// high; there is no backpressure. data_valid is a single-cycle strobe that
// coincides with data_out taking its new value; no acknowledge is expected.
//
// Build option: ADC_SAR_CONTINUOUS_EN -- when defined, DONE re-enters SAMPLE
// while en stays high, so one start launches back-to-back conversions.
//
// Every output is a register loaded from the next-state decode, so each
// output lines up with the state it belongs to and none has a
// combinational path from an input.
module adc3v_12bit_sar_ctrl
  import adc3v_12bit_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             comp_in,
  output logic             adc_ena,
  output logic             adc_reset,
  output logic             adc_hold,
  output logic [WIDTH-1:0] adc_dac_val,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int               IDX_W = idx_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB   = ONE << (WIDTH - 1);

  sar_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_dac, w_dac_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_adc_reset, w_adc_reset_nxt;
  logic             r_hold, r_busy, r_ena;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_tc;

  logic [WIDTH-1:0] w_trial_mask;
  logic [WIDTH-1:0] w_kept;

  adc3v_sar_timer #(.CNT_W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tmr_tc)
  );

  // The DAC register already carries the trial bit, so the decision only
  // has to clear it when the comparator says the held value is below.
  assign w_trial_mask = ONE << r_bit;
  assign w_kept       = comp_in ? r_dac : (r_dac & ~w_trial_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit       <= '0;
      r_dac       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_adc_reset <= 1'b0;
      r_hold      <= 1'b0;
      r_busy      <= 1'b0;
      r_ena       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit       <= w_bit_nxt;
      r_dac       <= w_dac_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_adc_reset <= w_adc_reset_nxt;
      r_hold      <= (w_state_nxt == ST_CONVERT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_ena       <= en;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_nxt       = r_bit;
    w_dac_nxt       = r_dac;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_adc_reset_nxt = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_val       = '0;

    case (r_state)
      ST_IDLE: begin
        w_dac_nxt = '0;
        if (en && start) begin
          w_state_nxt     = ST_SAMPLE;
          w_adc_reset_nxt = 1'b1;
          w_tmr_load      = 1'b1;
          w_tmr_val       = TMR_W'(SAMPLE_CYCLES - 1);
        end
      end

      ST_SAMPLE: begin
        if (w_tmr_tc) begin
          w_state_nxt = ST_CONVERT;
          w_dac_nxt   = MSB;
          w_bit_nxt   = IDX_W'(WIDTH - 1);
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(SETTLE_CYCLES - 1);
        end
      end

      ST_CONVERT: begin
        // Decision is taken on the last clock of each settle window.
        if (w_tmr_tc) begin
          if (r_bit == '0) begin
            w_state_nxt = ST_DONE;
            w_data_nxt  = w_kept;
            w_valid_nxt = 1'b1;
            w_dac_nxt   = '0;
          end else begin
            w_dac_nxt  = w_kept | (ONE << (r_bit - 1'b1));
            w_bit_nxt  = r_bit - 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
          end
        end
      end

      ST_DONE: begin
        w_dac_nxt = '0;
`ifdef ADC_SAR_CONTINUOUS_EN
        w_state_nxt     = ST_SAMPLE;
        w_adc_reset_nxt = 1'b1;
        w_tmr_load      = 1'b1;
        w_tmr_val       = TMR_W'(SAMPLE_CYCLES - 1);
`else
        w_state_nxt = ST_IDLE;
`endif
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_dac_nxt   = '0;
      end
    endcase

    // Disable wins over everything: abort without a result, keep data_out.
    if (!en) begin
      w_state_nxt     = ST_IDLE;
      w_bit_nxt       = r_bit;
      w_dac_nxt       = '0;
      w_data_nxt      = r_data;
      w_valid_nxt     = 1'b0;
      w_adc_reset_nxt = 1'b0;
      w_tmr_load      = 1'b0;
    end
  end

  assign adc_ena     = r_ena;
  assign adc_reset   = r_adc_reset;
  assign adc_hold    = r_hold;
  assign adc_dac_val = r_dac;
  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc3v_12bit_sar_ctrl.sv
// Self-checking bench for adc3v_12bit_sar_ctrl (default parameters).
// The comparator is modelled as an ideal analog input sitting half an LSB
// above model_code, so a correct controller resolves exactly model_code.
// Expected DAC trials come from a closed-form binary-search formula.
module tb_adc3v_12bit_sar_ctrl;
  import adc3v_12bit_pkg::*;

  localparam int W        = 12;
  localparam int SC       = 4;
  localparam int ST       = 2;
  localparam int DONE_CYC = 1 + SC + W * ST;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, en, start, comp_in;
  logic adc_ena, adc_reset, adc_hold, data_valid, busy;
  logic [W-1:0] adc_dac_val, data_out;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  adc3v_12bit_sar_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .start       (start),
    .comp_in     (comp_in),
    .adc_ena     (adc_ena),
    .adc_reset   (adc_reset),
    .adc_hold    (adc_hold),
    .adc_dac_val (adc_dac_val),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- comparator model ----------------
  logic [W-1:0] model_code;
  int           comp_mode;   // 0 = model, 1 = tied 0, 2 = tied 1

  always_comb begin
    case (comp_mode)
      1:       comp_in = 1'b0;
      2:       comp_in = 1'b1;
      default: comp_in = (model_code >= adc_dac_val);
    endcase
  end

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_data_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && data_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_valid", 32'(data_valid), 32'd0);
      else check_eq("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  // Trial k of a binary search for code: the k bits above are already
  // resolved, the next bit down is being tried.
  function automatic logic [W-1:0] exp_trial(input logic [W-1:0] code, input int k);
    int c, hi;
    c  = int'(code);
    hi = (c >> (W - k)) << (W - k);
    return W'(hi | (1 << (W - 1 - k)));
  endfunction

  // ---------------- driver ----------------
  task automatic run_conv(input logic [W-1:0] code, input int mode, input bit repulse,
                          input int drop_at, input int rst_at, input bit expect_done);
    int           vcyc, nvalid;
    logic [W-1:0] want;
    model_code = code;
    comp_mode  = mode;
    want       = (mode == 1) ? '0 : (mode == 2) ? '1 : code;
    if (expect_done) exp_q.push_back(want);
    vcyc   = -1;
    nvalid = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (data_valid) begin
        nvalid++;
        if (vcyc < 0) vcyc = cyc;
      end
      if (drop_at == 0 && rst_at == 0) begin
        if (cyc == 1) begin
          check_eq("sample_adc_reset", 32'(adc_reset), 32'd1);
          check_eq("sample_hold", 32'(adc_hold), 32'd0);
          check_eq("sample_busy", 32'(busy), 32'd1);
        end
        if (cyc == 2) check_eq("adc_reset_pulse_end", 32'(adc_reset), 32'd0);
        if (cyc > SC && cyc < DONE_CYC && ((cyc - SC - 1) % ST) == 0) begin
          check_eq($sformatf("trial%0d", (cyc - SC - 1) / ST), 32'(adc_dac_val),
                   32'(exp_trial(want, (cyc - SC - 1) / ST)));
          check_eq("convert_hold", 32'(adc_hold), 32'd1);
        end
        if (cyc == DONE_CYC) begin
          check_eq("done_hold", 32'(adc_hold), 32'd0);
          check_eq("done_dac", 32'(adc_dac_val), 32'd0);
          check_eq("done_busy", 32'(busy), 32'd1);
          check_eq("done_state", 32'(dbg_state), 32'(ST_DONE));
        end
        if (cyc == DONE_CYC + 1 || cyc == 40) begin
          check_eq("idle_busy", 32'(busy), 32'd0);
          check_eq("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        end
      end
      if (drop_at != 0 && cyc == drop_at + 1) begin
        check_eq("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_hold", 32'(adc_hold), 32'd0);
        check_eq("abort_dac", 32'(adc_dac_val), 32'd0);
        check_eq("abort_adc_ena", 32'(adc_ena), 32'd0);
        check_eq("abort_data_kept", 32'(data_out), 32'(exp_data_out));
      end
      if (drop_at != 0 && cyc == drop_at) en = 1'b0;
      if (rst_at != 0 && cyc == rst_at) begin
        reset = 1'b1;
        #1;
        check_eq("rst_adc_ena", 32'(adc_ena), 32'd0);
        check_eq("rst_adc_reset", 32'(adc_reset), 32'd0);
        check_eq("rst_hold", 32'(adc_hold), 32'd0);
        check_eq("rst_dac", 32'(adc_dac_val), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        exp_data_out = '0;
        @(negedge clk);
        reset = 1'b0;
        break;
      end
      if (repulse) start = (cyc == 5 || cyc == 20);
      @(negedge clk);
    end
    start = 1'b0;
    en    = 1'b1;
    if (expect_done) begin
      check_eq("valid_cycle", 32'(vcyc), 32'(DONE_CYC));
      check_eq("valid_count", 32'(nvalid), 32'd1);
      exp_data_out = want;
    end else begin
      check_eq("abort_valid_count", 32'(nvalid), 32'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset        = 1'b1;
    en           = 1'b0;
    start        = 1'b0;
    comp_mode    = 0;
    model_code   = '0;
    exp_data_out = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("reset_outputs", 32'({adc_ena, adc_reset, adc_hold, data_valid, busy}), 32'd0);
    check_eq("reset_dac", 32'(adc_dac_val), 32'd0);
    check_eq("reset_data_out", 32'(data_out), 32'd0);
    reset = 1'b0;

    // start must be ignored while disabled
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("start_when_disabled", 32'(busy), 32'd0);
    check_eq("adc_ena_low", 32'(adc_ena), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check_eq("adc_ena_follows", 32'(adc_ena), 32'd1);

`ifdef ADC_SAR_CONTINUOUS_EN
    begin
      logic [W-1:0] codes[3];
      int           k;
      codes[0] = 12'hA5C;
      codes[1] = W'($urandom_range(0, 4095));
      codes[2] = W'($urandom_range(0, 4095));
      for (int i = 0; i < 3; i++) exp_q.push_back(codes[i]);
      model_code = codes[0];
      comp_mode  = 0;
      k          = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
        if (data_valid) begin
          check_eq("cont_valid_cycle", 32'(cyc), 32'(DONE_CYC * (k + 1)));
          k++;
          if (k < 3) model_code = codes[k];
          else en = 1'b0;
        end
        @(negedge clk);
      end
      check_eq("cont_valid_count", 32'(k), 32'd3);
      en = 1'b1;
    end
`else
    run_conv(12'hA5C, 0, 1'b0, 0, 0, 1'b1);
    run_conv(W'($urandom_range(0, 4095)), 0, 1'b0, 15, 0, 1'b0);
    run_conv(W'($urandom_range(0, 4095)), 0, 1'b1, 0, 0, 1'b1);
    run_conv(12'h5A5, 1, 1'b0, 0, 0, 1'b1);
    run_conv(12'h5A5, 2, 1'b0, 0, 0, 1'b1);
    run_conv(W'($urandom_range(0, 4095)), 0, 1'b0, 0, 10, 1'b0);
    run_conv(12'h123, 0, 1'b0, 0, 0, 1'b1);
    repeat (4) run_conv(W'($urandom_range(0, 4095)), 0, 1'b0, 0, 0, 1'b1);
    run_conv(12'h000, 0, 1'b0, 0, 0, 1'b1);
    run_conv(12'hFFF, 0, 1'b0, 0, 0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
